sum_uart_reporter: RTL and testbench

Downstream consumer of the 4-bit adder's 5-bit sum (range 0..30).
- On a send request it latches the sum and converts it to two ASCII decimal digits.
- It then transmits the frame "DD\r\n" over a UART TX line, 8N1, LSB first.
- It sits between the adder output and the board's UART TX pin.

---
 rtl/sum_uart_pkg.sv | 30 +++
 rtl/uart_tx_byte.sv | 70 +++++++
 rtl/sum_uart_reporter.sv | 72 +++++++
 tb/tb_sum_uart_reporter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sum_uart_pkg.sv
// Shared constants, state encoding and decimal-split helpers for the sum UART reporter.
package sum_uart_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam int         FRAME_BYTES = 4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    // Out-of-range 31 lands in the top bucket and so reads as "31".
    function automatic logic [1:0] tens_of(input logic [4:0] value);
        if (value < 5'd10)      return 2'd0;
        else if (value < 5'd20) return 2'd1;
        else if (value < 5'd30) return 2'd2;
        else                    return 2'd3;
    endfunction

    function automatic logic [3:0] ones_of(input logic [4:0] value);
        logic [4:0] rem;
        case (tens_of(value))
            2'd0:    rem = value;
            2'd1:    rem = value - 5'd10;
            2'd2:    rem = value - 5'd20;
            default: rem = value - 5'd30;
        endcase
        return rem[3:0];
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with a valid/ready byte handshake; tx is registered.
// ready rises in the last cycle of the stop bit so a following byte starts with no gap.
module uart_tx_byte
    import sum_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] dat,
    input  logic       vld,
    output logic       rdy,
    output logic       tx
);

    localparam int             CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          bit_end;

    assign bit_end = (cnt == LAST);
    assign rdy     = (state == IDLE) || (state == STOP && bit_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else if (vld && rdy) begin
            shift   <= dat;
            state   <= START;
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= 1'b0;
        end else if (state != IDLE) begin
            if (!bit_end) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
                case (state)
                    START: begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx      <= shift[0];
                    end
                    DATA: begin
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[bit_idx + 3'd1];
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/sum_uart_reporter.sv
// Latches the adder sum on a send request and transmits "DD\r\n" over 8N1 UART.
// Requests arriving while busy are dropped; busy spans the whole 40-bit frame.
module sum_uart_reporter
    import sum_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] sum,
    input  logic       send,
    output logic       tx,
    output logic       busy,
    output logic [4:0] latched_sum
);

    logic [1:0] tens;
    logic [3:0] ones;
    logic [1:0] byte_idx;
    logic       accept;
    logic       ser_vld;
    logic       ser_rdy;
    logic [7:0] ser_dat;

    assign accept  = send && !busy;
    // byte_idx holds the next byte to hand off; it wraps to 0 once the LF has been taken.
    assign ser_vld = accept || (busy && byte_idx != 2'd0);

    // The first byte is handed off on the accepting edge, so it comes from the live sum.
    always_comb begin
        ser_dat = ASCII_ZERO + {6'd0, tens_of(sum)};
        if (busy) begin
            case (byte_idx)
                2'd1:    ser_dat = ASCII_ZERO + {4'd0, ones};
                2'd2:    ser_dat = ASCII_CR;
                2'd3:    ser_dat = ASCII_LF;
                default: ser_dat = ASCII_ZERO + {6'd0, tens};
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            latched_sum <= '0;
            tens        <= '0;
            ones        <= '0;
            byte_idx    <= '0;
        end else if (accept) begin
            busy        <= 1'b1;
            latched_sum <= sum;
            tens        <= tens_of(sum);
            ones        <= ones_of(sum);
            byte_idx    <= 2'd1;
        end else if (busy && ser_rdy) begin
            if (byte_idx == 2'd0) busy <= 1'b0;
            else                  byte_idx <= byte_idx + 2'd1;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .dat   (ser_dat),
        .vld   (ser_vld),
        .rdy   (ser_rdy),
        .tx    (tx)
    );

endmodule

// File: tb/tb_sum_uart_reporter.sv
// Randomized scoreboard bench: a frame-level model predicts bytes and waveform, a UART receiver checks tx.
module tb_sum_uart_reporter;

    localparam int CPB = 4;
    localparam int FL  = 40 * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] sum;
    logic       send;
    logic       tx;
    logic       busy;
    logic [4:0] latched_sum;

    sum_uart_reporter #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sum         (sum),
        .send        (send),
        .tx          (tx),
        .busy        (busy),
        .latched_sum (latched_sum)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Reference model: a frame occupies FL cycles after the accepting edge.
    int         m_cnt     = 0;
    int         m_frames  = 0;
    logic [4:0] m_latched = '0;
    logic [7:0] m_frame [4];
    logic [7:0] exp_q [$];

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_cnt     = 0;
                m_latched = '0;
                exp_q.delete();
            end else if (m_cnt != 0) begin
                m_cnt--;
            end else if (send) begin
                m_cnt      = FL;
                m_latched  = sum;
                m_frame[0] = 8'h30 + 8'(sum / 10);
                m_frame[1] = 8'h30 + 8'(sum % 10);
                m_frame[2] = 8'h0D;
                m_frame[3] = 8'h0A;
                for (int i = 0; i < 4; i++) exp_q.push_back(m_frame[i]);
                m_frames++;
            end
        end
    end

    // Per-cycle waveform check against the model's bit position in the frame.
    logic checking = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && checking) begin
                int p, bi, b, exp_tx;
                chk("busy", busy, (m_cnt != 0) ? 1 : 0);
                chk("latched_sum", latched_sum, m_latched);
                if (m_cnt == 0) begin
                    exp_tx = 1;
                end else begin
                    p  = FL - m_cnt;
                    bi = p / (10 * CPB);
                    b  = (p % (10 * CPB)) / CPB;
                    exp_tx = (b == 0) ? 0 : (b == 9) ? 1 : int'(m_frame[bi][b-1]);
                end
                chk("tx_wave", tx, exp_tx);
            end
        end
    end

    // Monitor: mid-bit sampling UART receiver, pops the scoreboard per decoded byte.
    int         rx_bytes = 0;
    logic       rx_on    = 1'b0;
    int         rx_t     = 0;
    logic [7:0] rx_shift = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rx_on = 1'b0;
            end else if (!rx_on) begin
                if (tx == 1'b0) begin
                    rx_on = 1'b1;
                    rx_t  = 0;
                end
            end else begin
                rx_t++;
                if (rx_t % CPB == CPB / 2) begin
                    int idx;
                    idx = rx_t / CPB;
                    if (idx >= 1 && idx <= 8) rx_shift[idx-1] = tx;
                    if (idx == 9) begin
                        rx_on = 1'b0;
                        rx_bytes++;
                        chk("stop_bit", tx, 1);
                        if (exp_q.size() == 0) begin
                            chk("unexpected_byte", rx_shift, -1);
                        end else begin
                            chk("rx_byte", rx_shift, exp_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic send_pulse(input logic [4:0] s);
        @(negedge clk);
        sum  = s;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 4 * FL && m_cnt != 0; i++) @(negedge clk);
        @(negedge clk);
        chk("idle_reached", busy, 0);
    endtask

    logic [4:0] bnd [5] = '{5'd0, 5'd9, 5'd10, 5'd30, 5'd31};

    initial begin
        int rx0, f0, toggles;
        logic prev;
        rst_n = 1'b0;
        send  = 1'b0;
        sum   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_latched", latched_sum, 0);
        checking = 1'b1;
        toggles = 0;
        prev = tx;
        repeat (20) begin
            @(negedge clk);
            if (tx != prev) toggles++;
            prev = tx;
        end
        chk("idle_toggles", toggles, 0);

        // First frame: start bit and busy one cycle after acceptance.
        rx0 = rx_bytes;
        send_pulse(5'd17);
        chk("first_busy", busy, 1);
        chk("first_tx", tx, 0);
        wait_idle();
        chk("latched_17", latched_sum, 17);
        chk("bytes_17", rx_bytes - rx0, 4);

        foreach (bnd[i]) begin
            send_pulse(bnd[i]);
            wait_idle();
        end

        // A second request mid-frame must be dropped.
        rx0 = rx_bytes;
        send_pulse(5'd12);
        repeat (20) @(negedge clk);
        send_pulse(5'd25);
        wait_idle();
        chk("ignored_latched", latched_sum, 12);
        chk("ignored_bytes", rx_bytes - rx0, 4);

        // Held send: back-to-back frames.
        rx0 = rx_bytes;
        f0  = m_frames;
        @(negedge clk);
        sum  = 5'd8;
        send = 1'b1;
        for (int i = 0; i < 4 * FL && m_frames < f0 + 2; i++) @(negedge clk);
        send = 1'b0;
        wait_idle();
        chk("held_bytes", rx_bytes - rx0, 8);

        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(5, 0)) @(negedge clk);
            send_pulse(5'($urandom_range(31, 0)));
            if ($urandom_range(1, 0) == 1) wait_idle();
        end
        wait_idle();

        // Reset in the data bits of the third byte.
        send_pulse(5'($urandom_range(31, 0)));
        for (int i = 0; i < 2 * FL && (FL - m_cnt) < 2 * 10 * CPB + 3 * CPB; i++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_tx", tx, 1);
        chk("async_rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rx0 = rx_bytes;
        send_pulse(5'd23);
        wait_idle();
        chk("post_rst_bytes", rx_bytes - rx0, 4);
        chk("post_rst_latched", latched_sum, 23);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
